bus_share_arb16: RTL and testbench

BUS_SHARE_ARB16 -- requirements
Module: bus_share_arb16

---
 rtl/bus_share_arb16.sv | 153 +++++++++++++++
 tb/tb_bus_share_arb16.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bus_share_arb16.sv
// Two-requester shared-bus arbiter with a registered 16-bit datapath.
// Round-robin on ties, bounded bursts per owner, handover with no idle gap.
module bus_share_arb16 #(
    parameter int unsigned MAXBURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        s,
    output logic [15:0] o,
    output logic        ov
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [3:0] CNT_TOP = 4'(MAXBURST - 1);

    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        last_r;

    logic [1:0]  state_s;
    logic [3:0]  cnt_s;
    logic        last_s;
    logic        xfer_s;
    logic [15:0] xdata_s;

    // Next-state, burst counter and transfer decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        xfer_s  = 1'b0;
        xdata_s = 16'h0000;
        case (state_r)
            IDLE: begin
                cnt_s = 4'd0;
                if (req0 && (!req1 || last_r)) begin
                    state_s = OWN0;
                    last_s  = 1'b0;
                end else if (req1) begin
                    state_s = OWN1;
                    last_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN0: begin
                if (!req0) begin
                    cnt_s = 4'd0;
                    if (req1) begin
                        state_s = OWN1;
                        last_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    xfer_s  = 1'b1;
                    xdata_s = i0;
                    // Burst limit: yield only if the other side is waiting
                    if (cnt_r == CNT_TOP) begin
                        if (req1) begin
                            state_s = OWN1;
                            last_s  = 1'b1;
                            cnt_s   = 4'd0;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    cnt_s = 4'd0;
                    if (req0) begin
                        state_s = OWN0;
                        last_s  = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    xfer_s  = 1'b1;
                    xdata_s = i1;
                    if (cnt_r == CNT_TOP) begin
                        if (req0) begin
                            state_s = OWN0;
                            last_s  = 1'b0;
                            cnt_s   = 4'd0;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Arbiter state and registered grant/select outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            last_r  <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            s       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            gnt0    <= (state_s == OWN0);
            gnt1    <= (state_s == OWN1);
            if (state_s == OWN0) begin
                s <= 1'b0;
            end else if (state_s == OWN1) begin
                s <= 1'b1;
            end else begin
                s <= s;
            end
        end
    end

    // Shared-bus data register; holds its value when nothing moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o  <= 16'h0000;
            ov <= 1'b0;
        end else begin
            ov <= xfer_s;
            if (xfer_s) begin
                o <= xdata_s;
            end else begin
                o <= o;
            end
        end
    end

endmodule

// File: tb/tb_bus_share_arb16.sv
// Directed-vector bench for bus_share_arb16 at MAXBURST=4.
module tb_bus_share_arb16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] i0 = 16'h0000;
    logic [15:0] i1 = 16'h0000;
    logic        gnt0;
    logic        gnt1;
    logic        s;
    logic [15:0] o;
    logic        ov;

    int n_vec = 0;
    int n_err = 0;

    bus_share_arb16 #(.MAXBURST(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .i0   (i0),
        .i1   (i1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .s    (s),
        .o    (o),
        .ov   (ov)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic eg0, input logic eg1,
                             input logic es, input logic [15:0] eo, input logic eov);
        check_val({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
        check_val({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
        check_val({tag, ".s"},    32'(s),    32'(es));
        check_val({tag, ".o"},    32'(o),    32'(eo));
        check_val({tag, ".ov"},   32'(ov),   32'(eov));
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check_all("rst_async", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        step();
        check_all("rst_held", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        step();
        check_all("idle", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Single requester: one-cycle grant, three words, back to IDLE
        req0 = 1'b1;
        step();
        check_all("a_grant", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        i0 = 16'h1111; step();
        check_all("a_w1", 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1);
        i0 = 16'h2222; step();
        check_all("a_w2", 1'b1, 1'b0, 1'b0, 16'h2222, 1'b1);
        i0 = 16'h3333; step();
        check_all("a_w3", 1'b1, 1'b0, 1'b0, 16'h3333, 1'b1);
        req0 = 1'b0; step();
        check_all("a_idle", 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0);

        // Tie after owner 0 finished goes to requester 1
        req0 = 1'b1; req1 = 1'b1; step();
        check_all("rr_tie", 1'b0, 1'b1, 1'b1, 16'h3333, 1'b0);

        // Both held: 4 transfers each, seamless handover
        for (int k = 0; k < 8; k++) begin
            i0 = 16'(16'hA000 + k);
            i1 = 16'(16'hB000 + k);
            step();
            check_all($sformatf("alt%0d", k),
                      (k >= 3 && k < 7), (k < 3 || k == 7), (k < 3 || k == 7),
                      (k < 4) ? 16'(16'hB000 + k) : 16'(16'hA000 + k), 1'b1);
        end

        // Owner 1 drops with 0 waiting: immediate switch, no transfer
        req1 = 1'b0; step();
        check_all("drop1", 1'b1, 1'b0, 1'b0, 16'hA007, 1'b0);
        req1 = 1'b1;
        i0 = 16'hC001; step();
        check_all("c_w1", 1'b1, 1'b0, 1'b0, 16'hC001, 1'b1);
        i0 = 16'hC002; step();
        check_all("c_w2", 1'b1, 1'b0, 1'b0, 16'hC002, 1'b1);
        req0 = 1'b0; step();
        check_all("drop0", 1'b0, 1'b1, 1'b1, 16'hC002, 1'b0);

        // Counter restarted on handover: a full burst of 4 before yielding
        req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i1 = 16'(16'hD100 + k);
            step();
            check_all($sformatf("cnt%0d", k), (k == 3), (k < 3), (k < 3),
                      16'(16'hD100 + k), 1'b1);
        end

        // Reset between edges in mid-burst
        i0 = 16'hD001; step();
        check_all("pre_rst", 1'b1, 1'b0, 1'b0, 16'hD001, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_all("mid_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #2 rst = 1'b0;
        step();
        check_all("post_rst_tie", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Requester 1 alone: no preemption, stays after counter saturates
        req0 = 1'b0; step();
        check_all("e_grant", 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
        for (int k = 0; k < 7; k++) begin
            i1 = 16'(16'hE000 + k);
            step();
            check_all($sformatf("solo%0d", k), 1'b0, 1'b1, 1'b1, 16'(16'hE000 + k), 1'b1);
        end
        req1 = 1'b0; step();
        check_all("idle_s_hold", 1'b0, 1'b0, 1'b1, 16'hE006, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Grants must be mutually exclusive at all times
    always @(negedge clk) begin
        if (gnt0 && gnt1) begin
            check_val("mutex", 32'({gnt0, gnt1}), 32'd0);
        end
    end

endmodule
